// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared AES (FIPS-197) tables and helpers for the encrypt and
//               decrypt datapaths: S-box, round constants, xtime, word and
//               state transforms (forward and inverse), FSM state encoding.
//               State byte order: byte 0 = bits [127:120], column-major, so
//               byte i sits in column i/4, row i%4.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for round 1..10; other indices are never used.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return r;
  endfunction

  // Row r rotates left by r: out(row, col) = in(row, (col + row) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Coefficients 0e/0b/0d/09 built from xtime multiples (x2, x4, x8).
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4], mb [4], md [4], me [4];
    logic [7:0]   x2, x4, x8;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        a[k]  = s[127-32*c-8*k -: 8];
        x2    = xtime(a[k]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[k] = x8 ^ a[k];
        mb[k] = x8 ^ x2 ^ a[k];
        md[k] = x8 ^ x4 ^ a[k];
        me[k] = x8 ^ x4 ^ x2;
      end
      r[127-32*c -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[119-32*c -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[111-32*c -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[103-32*c -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return r;
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_key_round.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_round
// Description : One step of the AES-128 key schedule, purely combinational.
//               Produces the next 128-bit round key from the current one.
// Ports       : rk_i   [127:0] current round key
//               rcon_i [7:0]   round constant for the key being produced
//               rk_o   [127:0] next round key
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] rk_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_i;
  assign temp = sub_word(rot_word(w3)) ^ {rcon_i, 24'h000000};

  // Each new word chains off the previously generated one.
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_o = {n0, n1, n2, n3};

endmodule : aes_key_round
`default_nettype wire

// File: rtl/aes_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_encrypt_iter
// Description : Iterative AES-128 encryptor, one round per clock. Round keys
//               are expanded on the fly alongside the datapath. Accepts a
//               block on in_valid/in_ready (IDLE only) and presents the
//               ciphertext on out_valid/out_ready.
// Ports       : clk, rst        clock, synchronous active-high reset
//               in_valid/ready  input handshake
//               block_in, key_in 128-bit plaintext/key, byte 0 = [127:120]
//               out_valid/ready output handshake
//               result          ciphertext (holds last value in IDLE)
//               busy            high in ROUND or DONE
//               blk_cnt         completed-block count (AES_ENC_CNT_EN only)
// Macro       : AES_ENC_CNT_EN  adds the blk_cnt port and counter
// Revision    : 1.0 - initial release
// ============================================================================
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     block_in,
  input  logic [127:0]     key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     result,
  output logic             busy
`ifdef AES_ENC_CNT_EN
  ,
  output logic [CNT_W-1:0] blk_cnt
`endif
);

  if (NR != 10) begin : g_nr_check
    $error("aes_encrypt_iter: only NR=10 (AES-128) is supported");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("aes_encrypt_iter: CNT_W must be at least 1");
  end

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] data_q, data_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] rk_next;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic         last_round;

  aes_key_round u_key_round (
    .rk_i   (rk_q),
    .rcon_i (rcon(rnd_q)),
    .rk_o   (rk_next)
  );

  assign last_round = (rnd_q == 4'(NR));
  assign shifted    = shift_rows(sub_bytes(data_q));
  assign mixed      = last_round ? shifted : mix_columns(shifted);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      data_q <= '0;
      rk_q   <= '0;
      rnd_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      data_q <= data_d;
      rk_q   <= rk_d;
      rnd_q  <= rnd_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    data_d    = data_q;
    rk_d      = rk_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Initial AddRoundKey happens at load time so ROUND starts at round 1.
          data_d = block_in ^ key_in;
          rk_d   = key_in;
          rnd_d  = 4'd1;
          fsm_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        busy   = 1'b1;
        rk_d   = rk_next;
        data_d = mixed ^ rk_next;
        rnd_d  = rnd_q + 4'd1;
        if (last_round) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // data_q is frozen outside ROUND, so it doubles as the stable result.
  assign result = data_q;

`ifdef AES_ENC_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign blk_cnt = cnt_q;
`endif

endmodule : aes_encrypt_iter
`default_nettype wire
